// File: rtl/spdif_sample_feeder.sv
// Stereo PCM FIFO feeding the S/PDIF transmitter. It pops one pair per frame on the address 1->0 edge and outputs zeros on underrun.
// data_out is registered: 2 clk after a frame edge, 1 clk after a channel change. sample_ready is low only while the FIFO is full.
module spdif_sample_feeder #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SAMPLE_BITS = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        sample_valid,
   output logic                        sample_ready,
   input  logic [SAMPLE_BITS-1:0]      sample_left,
   input  logic [SAMPLE_BITS-1:0]      sample_right,
   input  logic                        address_in,
   output logic [23:0]                 data_out,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        frame_strobe,
   output logic                        underrun,
   input  logic                        underrun_clear
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

   logic [SAMPLE_BITS-1:0] mem_l [FIFO_DEPTH];
   logic [SAMPLE_BITS-1:0] mem_r [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [SAMPLE_BITS-1:0] hold_l;
   logic [SAMPLE_BITS-1:0] hold_r;
   logic                   addr_prev;
   logic                   fb;
   logic                   push;
   logic                   pop;
   logic                   empty;

   // Left-justify so the sample MSB (sign bit) lands on bit 23.
   function automatic logic [23:0] justify(input logic [SAMPLE_BITS-1:0] s);
      logic [23:0] w;
      w = 24'(s);
      return w << (24 - SAMPLE_BITS);
   endfunction

   assign sample_ready = (level != FULL);
   assign empty        = (level == '0);
   assign push         = sample_valid & sample_ready;
   assign fb           = addr_prev & ~address_in;
   assign pop          = fb & ~empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_l[wr_ptr] <= sample_left;
         mem_r[wr_ptr] <= sample_right;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         hold_l       <= '0;
         hold_r       <= '0;
         data_out     <= '0;
         frame_strobe <= 1'b0;
         underrun     <= 1'b0;
         addr_prev    <= 1'b0;
      end else begin
         addr_prev    <= address_in;
         frame_strobe <= fb;

         if (push)
            wr_ptr <= wr_ptr + PW'(1);

         // A boundary with nothing buffered mutes rather than replaying the last pair.
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            hold_l <= mem_l[rd_ptr];
            hold_r <= mem_r[rd_ptr];
         end else if (fb) begin
            hold_l <= '0;
            hold_r <= '0;
         end

         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         if (fb && empty)
            underrun <= 1'b1;
         else if (underrun_clear)
            underrun <= 1'b0;

         data_out <= address_in ? justify(hold_r) : justify(hold_l);
      end
   end
endmodule

// File: tb/tb_spdif_sample_feeder.sv
// Bench for spdif_sample_feeder: two instances (depth 8 and depth 4) checked against a queue-based frame model.
module tb_spdif_sample_feeder;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        address_in = 1'b0;
   logic        underrun_clear = 1'b0;
   logic        sv   [2];
   logic [15:0] sl   [2];
   logic [15:0] sr   [2];
   logic        rdy  [2];
   logic        fs   [2];
   logic        ur   [2];
   logic [23:0] dout [2];
   logic [3:0]  lvl0;
   logic [2:0]  lvl1;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   spdif_sample_feeder #(.FIFO_DEPTH(8), .SAMPLE_BITS(16)) dut8 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sv[0]), .sample_ready(rdy[0]),
      .sample_left(sl[0]), .sample_right(sr[0]), .address_in(address_in),
      .data_out(dout[0]), .level(lvl0), .frame_strobe(fs[0]), .underrun(ur[0]),
      .underrun_clear(underrun_clear));

   spdif_sample_feeder #(.FIFO_DEPTH(4), .SAMPLE_BITS(16)) dut4 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sv[1]), .sample_ready(rdy[1]),
      .sample_left(sl[1]), .sample_right(sr[1]), .address_in(address_in),
      .data_out(dout[1]), .level(lvl1), .frame_strobe(fs[1]), .underrun(ur[1]),
      .underrun_clear(underrun_clear));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Frame-level model: a queue of {left,right} pairs, the pair currently being
   // transmitted, and the sticky underrun bit.
   for (genvar g = 0; g < 2; g++) begin : mdl
      localparam int DEP = (g == 0) ? 8 : 4;
      logic [31:0] q [$];
      logic [15:0] hl = 16'h0;
      logic [15:0] hr = 16'h0;
      logic [23:0] ed = 24'h0;
      logic        es = 1'b0;
      logic        eu = 1'b0;
      logic        prev = 1'b0;
      logic [3:0]  lv;
      assign lv = (g == 0) ? lvl0 : {1'b0, lvl1};

      always @(posedge clk or negedge reset_n) begin
         logic        psh;
         logic        boundary;
         logic [31:0] t;
         if (!reset_n) begin
            q.delete();
            hl = 16'h0; hr = 16'h0; ed = 24'h0;
            es = 1'b0;  eu = 1'b0;  prev = 1'b0;
         end else begin
            psh      = sv[g] && (q.size() < DEP);
            boundary = prev && !address_in;
            ed       = address_in ? {hr, 8'h00} : {hl, 8'h00};
            es       = boundary;
            if (boundary && q.size() == 0) begin
               hl = 16'h0; hr = 16'h0; eu = 1'b1;
            end else begin
               if (boundary) begin
                  t  = q.pop_front();
                  hl = t[31:16];
                  hr = t[15:0];
               end
               if (underrun_clear) eu = 1'b0;
            end
            if (psh) q.push_back({sl[g], sr[g]});
            prev = address_in;
         end
      end

      always @(negedge clk) begin
         check($sformatf("dut%0d data_out", g), 32'(dout[g]), 32'(ed));
         check($sformatf("dut%0d level", g), 32'(lv), 32'(q.size()));
         check($sformatf("dut%0d sample_ready", g), 32'(rdy[g]), 32'(q.size() < DEP));
         check($sformatf("dut%0d frame_strobe", g), 32'(fs[g]), 32'(es));
         check($sformatf("dut%0d underrun", g), 32'(ur[g]), 32'(eu));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push0(input logic [15:0] l, input logic [15:0] r);
      int k;
      sl[0] = l; sr[0] = r; sv[0] = 1'b1;
      k = 0;
      while (!rdy[0] && k < 50) begin
         tick();
         k++;
      end
      check("push0 ready wait", 32'(k < 50), 32'h1);
      tick();
      sv[0] = 1'b0;
   endtask

   task automatic frame();
      address_in = 1'b1;
      repeat (3) tick();
      address_in = 1'b0;
      repeat (3) tick();
   endtask

   // mode 0: random address/valid/clear; mode 1: 4+4 cycle subframes, dut4 producer always valid.
   task automatic run(input int n, input int mode);
      logic pushed [2];
      pushed[0] = 1'b0; pushed[1] = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (mode == 1) address_in = ((c / 4) % 2 == 0);
         else if ($urandom_range(0, 3) == 0) address_in = ~address_in;
         for (int g = 0; g < 2; g++) begin
            if (!sv[g] || pushed[g]) begin
               sv[g] = (mode == 1 && g == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
               sl[g] = 16'($urandom);
               sr[g] = 16'($urandom);
            end
         end
         underrun_clear = (mode == 0) && ($urandom_range(0, 15) == 0);
         for (int g = 0; g < 2; g++) pushed[g] = sv[g] && rdy[g];
         tick();
      end
      underrun_clear = 1'b0;
   endtask

   initial begin
      sv[0] = 1'b0; sv[1] = 1'b0;
      sl[0] = 16'h0; sl[1] = 16'h0; sr[0] = 16'h0; sr[1] = 16'h0;
      tick(); tick();
      reset_n = 1'b1;
      check("reset data_out", 32'(dout[0]), 32'h0);
      check("reset level", 32'(lvl0), 32'h0);
      check("reset sample_ready", 32'(rdy[0]), 32'h1);
      check("reset underrun", 32'(ur[0]), 32'h0);

      // Single pair through one frame.
      address_in = 1'b1; tick();
      push0(16'h1234, 16'h8001);
      check("one pair level", 32'(lvl0), 32'h1);
      address_in = 1'b0; tick();
      check("edge strobe", 32'(fs[0]), 32'h1);
      check("edge level", 32'(lvl0), 32'h0);
      tick();
      check("left after 2", 32'(dout[0]), 32'h123400);
      check("strobe one cycle", 32'(fs[0]), 32'h0);
      address_in = 1'b1; tick();
      check("right after 1", 32'(dout[0]), 32'h800100);

      // Fill to full, hold off a ninth pair until one pop.
      for (int i = 0; i < 8; i++) push0(16'(i * 16'h0111 + 1), 16'(16'hF000 - i));
      check("full level", 32'(lvl0), 32'h8);
      check("full not ready", 32'(rdy[0]), 32'h0);
      sl[0] = 16'h7777; sr[0] = 16'h9999; sv[0] = 1'b1;
      repeat (3) tick();
      check("held off level", 32'(lvl0), 32'h8);
      address_in = 1'b0; tick();
      check("after pop level", 32'(lvl0), 32'h7);
      check("after pop ready", 32'(rdy[0]), 32'h1);
      tick();
      sv[0] = 1'b0;
      check("ninth accepted", 32'(lvl0), 32'h8);
      repeat (8) frame();
      check("drained level", 32'(lvl0), 32'h0);

      // Underrun boundary coinciding with a push.
      address_in = 1'b1; tick();
      address_in = 1'b0; sl[0] = 16'hABCD; sr[0] = 16'h5555; sv[0] = 1'b1; tick();
      sv[0] = 1'b0;
      check("underrun set", 32'(ur[0]), 32'h1);
      check("push during underrun", 32'(lvl0), 32'h1);
      tick();
      check("muted left", 32'(dout[0]), 32'h0);
      address_in = 1'b1; tick();
      check("muted right", 32'(dout[0]), 32'h0);
      tick();
      address_in = 1'b0; tick(); tick();
      check("stored left", 32'(dout[0]), 32'hABCD00);
      address_in = 1'b1; tick();
      check("stored right", 32'(dout[0]), 32'h555500);

      // Clear versus simultaneous event.
      underrun_clear = 1'b1; tick(); underrun_clear = 1'b0;
      check("clear alone", 32'(ur[0]), 32'h0);
      address_in = 1'b0; underrun_clear = 1'b1; tick(); underrun_clear = 1'b0;
      check("set beats clear", 32'(ur[0]), 32'h1);
      tick();
      underrun_clear = 1'b1; tick(); underrun_clear = 1'b0;
      check("later clear", 32'(ur[0]), 32'h0);

      run(400, 0);

      // Depth-4 streaming with wrap and a reset pulse mid-stream.
      run(64, 1);
      reset_n = 1'b0;
      #1;
      check("rst data_out d4", 32'(dout[1]), 32'h0);
      check("rst level d4", 32'(lvl1), 32'h0);
      check("rst data_out d8", 32'(dout[0]), 32'h0);
      tick();
      reset_n = 1'b1;
      run(160, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
